// File: rtl/spi_host_cmd_pkg.sv
// spi_host_cmd_pkg: shared types and helpers for the SPI host data path.
//   speed_e        - bus speed selector (Standard/Dual/Quad/Octal)
//   bits_per_shift - bits moved per shift strobe for a speed and lane count
package spi_host_cmd_pkg;

  typedef enum logic [1:0] {
    SpeedStd   = 2'b00,
    SpeedDual  = 2'b01,
    SpeedQuad  = 2'b10,
    SpeedOctal = 2'b11
  } speed_e;

  // Octal on a 4-lane build has no legal mapping; report 0 so the shifter
  // holds its word and drives no lanes.
  function automatic logic [3:0] bits_per_shift(logic [1:0] speed, int unsigned num_lanes);
    logic [3:0] bps;
    case (speed)
      SpeedStd:  bps = 4'd1;
      SpeedDual: bps = 4'd2;
      SpeedQuad: bps = 4'd4;
      default:   bps = (num_lanes == 8) ? 4'd8 : 4'd0;
    endcase
    return bps;
  endfunction

endpackage

// File: rtl/spi_host_wide_shifter_if.sv
// spi_host_wide_shifter_if: control, TX, RX and lane signals between the SPI
// host command FSM (master) and the wide data shifter (slave).
//   sw_rst_i, speed_i, lsb_first_i      - mode / soft clear
//   wr_*, rd_*, shift/sample/... strobes - FSM handshakes
//   tx_*, rx_*                          - word streams
//   sd_i / sd_o                         - physical data lanes
interface spi_host_wide_shifter_if #(
  parameter int WordWidth = 8,
  parameter int NumLanes  = 8,
  parameter int RxDepth   = 2
);
  localparam int LevelW = $clog2(RxDepth + 1);

  logic                 sw_rst_i;
  logic [1:0]           speed_i;
  logic                 lsb_first_i;
  logic                 wr_en_i;
  logic                 wr_ready_o;
  logic                 rd_en_i;
  logic                 rd_ready_o;
  logic                 shift_en_i;
  logic                 sample_en_i;
  logic                 full_cyc_i;
  logic                 last_read_i;
  logic                 last_write_i;
  logic [WordWidth-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;
  logic                 tx_flush_o;
  logic [WordWidth-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 rx_ready_i;
  logic                 rx_last_o;
  logic [LevelW-1:0]    rx_level_o;
  logic                 word_done_o;
  logic [NumLanes-1:0]  sd_i;
  logic [NumLanes-1:0]  sd_o;

  modport master (
    output sw_rst_i, speed_i, lsb_first_i, wr_en_i, rd_en_i, shift_en_i,
           sample_en_i, full_cyc_i, last_read_i, last_write_i, tx_data_i,
           tx_valid_i, rx_ready_i, sd_i,
    input  wr_ready_o, rd_ready_o, tx_ready_o, tx_flush_o, rx_data_o,
           rx_valid_o, rx_last_o, rx_level_o, word_done_o, sd_o
  );

  modport slave (
    input  sw_rst_i, speed_i, lsb_first_i, wr_en_i, rd_en_i, shift_en_i,
           sample_en_i, full_cyc_i, last_read_i, last_write_i, tx_data_i,
           tx_valid_i, rx_ready_i, sd_i,
    output wr_ready_o, rd_ready_o, tx_ready_o, tx_flush_o, rx_data_o,
           rx_valid_o, rx_last_o, rx_level_o, word_done_o, sd_o
  );

endinterface

// File: rtl/spi_host_rx_fifo.sv
// spi_host_rx_fifo: small synchronous FIFO for captured RX words.
//   clk_i, rst_i (async, active-high), clr_i (sync clear, wins over push/pop)
//   push_i/wdata_i - write (caller guarantees space or a same-cycle pop)
//   pop_i          - read  (caller guarantees non-empty)
//   rdata_o        - head entry; level_o occupancy; full_o / empty_o flags
module spi_host_rx_fifo #(
  parameter int Depth = 2,
  parameter int Width = 9
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PtrW   = $clog2(Depth);
  localparam int LevelW = $clog2(Depth + 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      for (int i = 0; i < Depth; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop_i) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LevelW'(1);
        2'b01:   level_d = level_q - LevelW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LevelW'(Depth));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/spi_host_wide_shifter.sv
// spi_host_wide_shifter: parametrised SPI host data shifter with selectable
// lane count per shift (1/2/4/8), MSB/LSB-first order, per-word bit counter
// and an RX capture FIFO.
//   clk_i - clock
//   rst_i - asynchronous active-high reset
//   bus   - spi_host_wide_shifter_if.slave (FSM strobes, TX/RX streams, lanes)
module spi_host_wide_shifter
  import spi_host_cmd_pkg::*;
#(
  parameter int WordWidth = 8,
  parameter int NumLanes  = 8,
  parameter int RxDepth   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  spi_host_wide_shifter_if.slave bus
);
  localparam int W    = WordWidth;
  localparam int CntW = $clog2(WordWidth + 1);

  logic [W-1:0]        sr_q, sr_d;
  logic [W-1:0]        shifted;
  logic [W-1:0]        nb_w;
  logic [NumLanes-1:0] sd_i_q, sd_i_d;
  logic [NumLanes-1:0] next_bits;
  logic [NumLanes-1:0] lane_mask;
  logic [NumLanes-1:0] sd_o_w;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW:0]       cnt_sum;
  logic [3:0]          bps;
  logic                load;
  logic                push;
  logic                pop;
  logic                rd_ready;
  logic                fifo_full;
  logic                fifo_empty;
  logic [W:0]          fifo_rdata;

  assign bps       = bits_per_shift(bus.speed_i, NumLanes);
  assign next_bits = bus.full_cyc_i ? bus.sd_i : sd_i_q;
  // Low bps lanes enabled; bps == 0 masks every lane.
  assign lane_mask = NumLanes'((9'd1 << bps) - 9'd1);
  assign nb_w      = W'(next_bits & lane_mask);
  assign load      = bus.wr_en_i & bus.tx_valid_i;

  always_comb begin
    shifted = sr_q;
    sd_o_w  = '0;
    if (bps != 4'd0) begin
      if (bus.lsb_first_i) begin
        shifted = (sr_q >> bps) | (nb_w << (W - int'(bps)));
        sd_o_w  = NumLanes'(sr_q) & lane_mask;
      end else begin
        shifted = (sr_q << bps) | nb_w;
        sd_o_w  = NumLanes'(sr_q >> (W - int'(bps))) & lane_mask;
      end
    end
  end

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sd_i_d  = sd_i_q;
    cnt_sum = {1'b0, cnt_q} + (CntW+1)'(bps);
    if (bus.sw_rst_i) begin
      sr_d   = '0;
      cnt_d  = '0;
      sd_i_d = '0;
    end else begin
      if (load) begin
        sr_d  = bus.tx_data_i;
        cnt_d = '0;
      end else if (bus.shift_en_i) begin
        sr_d  = shifted;
        cnt_d = (cnt_sum >= (CntW+1)'(W)) ? CntW'(W) : cnt_sum[CntW-1:0];
      end
      if (bus.sample_en_i) sd_i_d = bus.sd_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      sd_i_q <= '0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      sd_i_q <= sd_i_d;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop      = ~fifo_empty & bus.rx_ready_i;
  assign rd_ready = ~fifo_full | pop;
  assign push     = bus.rd_en_i & rd_ready;

  spi_host_rx_fifo #(
    .Depth (RxDepth),
    .Width (W + 1)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (bus.sw_rst_i),
    .push_i  (push),
    .wdata_i ({bus.last_read_i, shifted}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .level_o (bus.rx_level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.sd_o        = sd_o_w;
  assign bus.wr_ready_o  = bus.tx_valid_i;
  assign bus.tx_ready_o  = bus.wr_en_i;
  assign bus.tx_flush_o  = bus.last_write_i;
  assign bus.rd_ready_o  = rd_ready;
  assign bus.rx_valid_o  = ~fifo_empty;
  assign bus.rx_data_o   = fifo_rdata[W-1:0];
  assign bus.rx_last_o   = fifo_rdata[W];
  assign bus.word_done_o = (cnt_q == CntW'(W));

endmodule
